pll_lock_sequencer: RTL and testbench

- Controls one dynamic-phase/duty PLL instance: runs power-up reset, waits for lock with timeout and retries, qualifies lock stability, then releases the downstream system reset.
- Serialises runtime phase/duty change requests onto the PLL PSDA/DUTYDA inputs through a req/ack handshake.
- Runs on the free-running board reference clock (50 MHz), never on a PLL output.

---
 rtl/pll_lock_sequencer_if.sv | 25 ++
 rtl/pll_lock_sequencer.sv | 249 ++++++++++++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pll_lock_sequencer_if.sv
// Phase/duty update handshake between a requester and the PLL lock sequencer.
// The requester holds cfg_req and the data stable until cfg_ack pulses.
interface pll_lock_sequencer_if;
    logic       cfg_req;
    logic [3:0] cfg_psda;
    logic [3:0] cfg_duty;
    logic       cfg_ack;
    logic       cfg_busy;

    modport master (
        output cfg_req,
        output cfg_psda,
        output cfg_duty,
        input  cfg_ack,
        input  cfg_busy
    );

    modport slave (
        input  cfg_req,
        input  cfg_psda,
        input  cfg_duty,
        output cfg_ack,
        output cfg_busy
    );
endinterface

// File: rtl/pll_lock_sequencer.sv
// PLL power-up/lock sequencer with phase/duty update serialisation.
// Runs on the free-running reference clock; PLL LOCK is resynchronised here.
//
//   state       | meaning
//   ------------+--------------------------------------------------------
//   S_RESET     | pll_reset held high for RST_CYCLES
//   S_WAIT_LOCK | waiting for lock_s, times out after LOCK_TIMEOUT cycles
//   S_STABLE    | counting STABLE_CYCLES consecutive locked cycles
//   S_READY     | locked and stable, downstream reset released
//   S_APPLY     | one cycle driving the latched PSDA/DUTYDA onto the PLL
//   S_SETTLE    | SETTLE_CYCLES wait after a phase/duty change
//   S_FAULT     | retries exhausted, only rst leaves this state
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES    = 64,
    parameter int unsigned LOCK_TIMEOUT  = 65536,
    parameter int unsigned STABLE_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES = 256,
    parameter int unsigned MAX_RETRY     = 3,
    parameter logic [3:0]  PSDA_INIT     = 4'b0000,
    parameter logic [3:0]  DUTY_INIT     = 4'b1000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       pll_lock_i,
    output logic                       pll_reset_o,
    output logic [3:0]                 pll_psda_o,
    output logic [3:0]                 pll_dutyda_o,
    pll_lock_sequencer_if.slave        cfg,
    output logic                       ready_o,
    output logic                       sys_rst_o,
    output logic                       fault_o,
    output logic [3:0]                 retry_cnt_o,
    output logic [7:0]                 lock_lost_cnt_o
);

    // One shared timer, sized for the longest of the four waits.
    localparam int unsigned T_MAX_A = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int unsigned T_MAX_B = (STABLE_CYCLES > SETTLE_CYCLES) ? STABLE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned T_MAX   = (T_MAX_A > T_MAX_B) ? T_MAX_A : T_MAX_B;
    localparam int          TW      = $clog2(T_MAX + 1);
    localparam int          RW      = $clog2(MAX_RETRY + 1);

    localparam logic [TW-1:0] RST_TC    = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] LOCK_TC   = TW'(LOCK_TIMEOUT - 1);
    localparam logic [TW-1:0] STABLE_TC = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] SETTLE_TC = TW'(SETTLE_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

    typedef enum logic [2:0] {
        S_RESET,
        S_WAIT_LOCK,
        S_STABLE,
        S_READY,
        S_APPLY,
        S_SETTLE,
        S_FAULT
    } state_t;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic [7:0]    lost_q, lost_d;
    logic [3:0]    psda_q, psda_d;
    logic [3:0]    duty_q, duty_d;
    logic [3:0]    req_psda_q, req_psda_d;
    logic [3:0]    req_duty_q, req_duty_d;
    logic          pll_reset_q, pll_reset_d;
    logic          ack_q, ack_d;
    logic          busy_q, busy_d;
    logic          ready_q, ready_d;
    logic          sys_rst_q, sys_rst_d;
    logic          fault_q, fault_d;
    logic          lock_meta_q, lock_s_q;
    logic          lock_loss;

    // Two-flop synchroniser for the asynchronous PLL LOCK.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
        end else begin
            lock_meta_q <= pll_lock_i;
            lock_s_q    <= lock_meta_q;
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        lost_d      = lost_q;
        psda_d      = psda_q;
        duty_d      = duty_q;
        req_psda_d  = req_psda_q;
        req_duty_d  = req_duty_q;
        pll_reset_d = pll_reset_q;
        ack_d       = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;
        sys_rst_d   = sys_rst_q;
        fault_d     = fault_q;
        lock_loss   = 1'b0;

        case (state_q)
            S_RESET: begin
                if (timer_q == RST_TC) begin
                    state_d     = S_WAIT_LOCK;
                    pll_reset_d = 1'b0;
                    timer_d     = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = S_STABLE;
                    timer_d = '0;
                end else if (timer_q == LOCK_TC) begin
                    retry_d     = retry_q + 1'b1;
                    timer_d     = '0;
                    pll_reset_d = 1'b1;
                    if (retry_d == RETRY_MAX) begin
                        state_d = S_FAULT;
                        fault_d = 1'b1;
                    end else begin
                        state_d = S_RESET;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!lock_s_q) begin
                    state_d = S_WAIT_LOCK;
                    timer_d = '0;
                end else if (timer_q == STABLE_TC) begin
                    state_d   = S_READY;
                    timer_d   = '0;
                    ready_d   = 1'b1;
                    sys_rst_d = 1'b0;
                    retry_d   = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_READY: begin
                // Lock loss outranks a pending update request.
                if (!lock_s_q) begin
                    lock_loss = 1'b1;
                end else if (cfg.cfg_req) begin
                    state_d    = S_APPLY;
                    req_psda_d = cfg.cfg_psda;
                    req_duty_d = cfg.cfg_duty;
                    ready_d    = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            S_APPLY: begin
                state_d = S_SETTLE;
                timer_d = '0;
                psda_d  = req_psda_q;
                duty_d  = req_duty_q;
            end
            S_SETTLE: begin
                if (!lock_s_q) begin
                    lock_loss = 1'b1;
                end else if (timer_q == SETTLE_TC) begin
                    state_d = S_READY;
                    timer_d = '0;
                    ack_d   = 1'b1;
                    busy_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d     = S_RESET;
                timer_d     = '0;
                pll_reset_d = 1'b1;
            end
        endcase

        // Lock lost while the downstream logic was running: rerun the
        // power-up sequence, keeping the last programmed PSDA/DUTYDA.
        if (lock_loss) begin
            state_d     = S_RESET;
            timer_d     = '0;
            pll_reset_d = 1'b1;
            ready_d     = 1'b0;
            busy_d      = 1'b0;
            sys_rst_d   = 1'b1;
            if (lost_q != 8'hFF) begin
                lost_d = lost_q + 8'd1;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RESET;
            timer_q     <= '0;
            retry_q     <= '0;
            lost_q      <= '0;
            psda_q      <= PSDA_INIT;
            duty_q      <= DUTY_INIT;
            req_psda_q  <= PSDA_INIT;
            req_duty_q  <= DUTY_INIT;
            pll_reset_q <= 1'b1;
            ack_q       <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            sys_rst_q   <= 1'b1;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            retry_q     <= retry_d;
            lost_q      <= lost_d;
            psda_q      <= psda_d;
            duty_q      <= duty_d;
            req_psda_q  <= req_psda_d;
            req_duty_q  <= req_duty_d;
            pll_reset_q <= pll_reset_d;
            ack_q       <= ack_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            sys_rst_q   <= sys_rst_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_reset_o     = pll_reset_q;
    assign pll_psda_o      = psda_q;
    assign pll_dutyda_o    = duty_q;
    assign cfg.cfg_ack     = ack_q;
    assign cfg.cfg_busy    = busy_q;
    assign ready_o         = ready_q;
    assign sys_rst_o       = sys_rst_q;
    assign fault_o         = fault_q;
    assign retry_cnt_o     = 4'(retry_q);
    assign lock_lost_cnt_o = lost_q;

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with short timer parameters.
module tb_pll_lock_sequencer;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       pll_reset;
    logic [3:0] pll_psda;
    logic [3:0] pll_dutyda;
    logic       ready;
    logic       sys_rst;
    logic       fault;
    logic [3:0] retry_cnt;
    logic [7:0] lock_lost_cnt;

    int n_cmp = 0;
    int n_err = 0;

    pll_lock_sequencer_if cfg_if ();

    pll_lock_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (32),
        .STABLE_CYCLES(8),
        .SETTLE_CYCLES(4),
        .MAX_RETRY    (2),
        .PSDA_INIT    (4'b0000),
        .DUTY_INIT    (4'b1000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .pll_lock_i     (pll_lock),
        .pll_reset_o    (pll_reset),
        .pll_psda_o     (pll_psda),
        .pll_dutyda_o   (pll_dutyda),
        .cfg            (cfg_if),
        .ready_o        (ready),
        .sys_rst_o      (sys_rst),
        .fault_o        (fault),
        .retry_cnt_o    (retry_cnt),
        .lock_lost_cnt_o(lock_lost_cnt)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag, input int budget);
        for (int i = 0; i < budget && ready !== 1'b1; i++) tick(1);
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic bring_up(input string tag);
        rst = 1'b1;
        cfg_if.cfg_req = 1'b0;
        pll_lock = 1'b1;
        tick(1);
        rst = 1'b0;
        wait_ready(tag, 30);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_prst"},  32'(pll_reset),       32'd1);
        chk({tag, "_psda"},  32'(pll_psda),        32'h0);
        chk({tag, "_duty"},  32'(pll_dutyda),      32'h8);
        chk({tag, "_ack"},   32'(cfg_if.cfg_ack),  32'd0);
        chk({tag, "_busy"},  32'(cfg_if.cfg_busy), 32'd0);
        chk({tag, "_ready"}, 32'(ready),           32'd0);
        chk({tag, "_srst"},  32'(sys_rst),         32'd1);
        chk({tag, "_fault"}, 32'(fault),           32'd0);
        chk({tag, "_retry"}, 32'(retry_cnt),       32'd0);
        chk({tag, "_lost"},  32'(lock_lost_cnt),   32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        pll_lock = 1'b0;
        cfg_if.cfg_req  = 1'b0;
        cfg_if.cfg_psda = 4'h0;
        cfg_if.cfg_duty = 4'h0;

        // Asynchronous reset takes effect before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk_reset_values("init");

        // Nominal power-up.
        tick(1);
        rst = 1'b0;
        tick(3);
        chk("t1_prst_hi", 32'(pll_reset), 32'd1);
        tick(1);
        chk("t1_prst_lo", 32'(pll_reset), 32'd0);
        chk("t1_srst_wait", 32'(sys_rst), 32'd1);
        tick(10);
        pll_lock = 1'b1;
        tick(10);
        chk("t1_rdy_early", 32'(ready), 32'd0);
        chk("t1_srst_early", 32'(sys_rst), 32'd1);
        tick(1);
        chk("t1_rdy", 32'(ready), 32'd1);
        chk("t1_srst", 32'(sys_rst), 32'd0);
        chk("t1_retry", 32'(retry_cnt), 32'd0);

        // Lock glitch in STABLE restarts the stable count.
        rst = 1'b1;
        pll_lock = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(4);
        chk("t2_prst_lo", 32'(pll_reset), 32'd0);
        pll_lock = 1'b1;
        tick(8);
        pll_lock = 1'b0;
        tick(2);
        pll_lock = 1'b1;
        tick(1);
        chk("t2_rdy_glitch", 32'(ready), 32'd0);
        chk("t2_srst_glitch", 32'(sys_rst), 32'd1);
        tick(9);
        chk("t2_rdy_early", 32'(ready), 32'd0);
        chk("t2_retry", 32'(retry_cnt), 32'd0);
        tick(1);
        chk("t2_rdy", 32'(ready), 32'd1);

        // Timeout, retry, then FAULT.
        rst = 1'b1;
        pll_lock = 1'b0;
        tick(1);
        rst = 1'b0;
        tick(35);
        chk("t3_retry0", 32'(retry_cnt), 32'd0);
        chk("t3_prst_lo", 32'(pll_reset), 32'd0);
        tick(1);
        chk("t3_retry1", 32'(retry_cnt), 32'd1);
        chk("t3_prst_hi", 32'(pll_reset), 32'd1);
        chk("t3_fault0", 32'(fault), 32'd0);
        tick(35);
        chk("t3_fault_early", 32'(fault), 32'd0);
        chk("t3_prst_lo2", 32'(pll_reset), 32'd0);
        tick(1);
        chk("t3_fault", 32'(fault), 32'd1);
        chk("t3_fault_prst", 32'(pll_reset), 32'd1);
        chk("t3_fault_srst", 32'(sys_rst), 32'd1);
        chk("t3_retry2", 32'(retry_cnt), 32'd2);
        pll_lock = 1'b1;
        tick(20);
        chk("t3_sticky_fault", 32'(fault), 32'd1);
        chk("t3_sticky_prst", 32'(pll_reset), 32'd1);
        chk("t3_sticky_ready", 32'(ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("t3_rst_fault", 32'(fault), 32'd0);
        chk("t3_rst_retry", 32'(retry_cnt), 32'd0);

        // Config update in READY.
        bring_up("t4_up");
        cfg_if.cfg_req  = 1'b1;
        cfg_if.cfg_psda = 4'h5;
        cfg_if.cfg_duty = 4'h6;
        tick(1);
        chk("t4_rdy_fall", 32'(ready), 32'd0);
        chk("t4_busy", 32'(cfg_if.cfg_busy), 32'd1);
        chk("t4_psda_old", 32'(pll_psda), 32'h0);
        chk("t4_srst_apply", 32'(sys_rst), 32'd0);
        tick(1);
        chk("t4_psda", 32'(pll_psda), 32'h5);
        chk("t4_duty", 32'(pll_dutyda), 32'h6);
        tick(3);
        chk("t4_ack_early", 32'(cfg_if.cfg_ack), 32'd0);
        chk("t4_srst_settle", 32'(sys_rst), 32'd0);
        tick(1);
        chk("t4_ack", 32'(cfg_if.cfg_ack), 32'd1);
        chk("t4_rdy", 32'(ready), 32'd1);
        chk("t4_busy_done", 32'(cfg_if.cfg_busy), 32'd0);
        chk("t4_srst", 32'(sys_rst), 32'd0);
        cfg_if.cfg_req = 1'b0;
        tick(1);
        chk("t4_ack_pulse", 32'(cfg_if.cfg_ack), 32'd0);
        chk("t4_rdy_hold", 32'(ready), 32'd1);

        // Lock loss during SETTLE; request held across the re-lock.
        bring_up("t5_up");
        cfg_if.cfg_req  = 1'b1;
        cfg_if.cfg_psda = 4'h5;
        cfg_if.cfg_duty = 4'h6;
        tick(2);
        chk("t5_psda", 32'(pll_psda), 32'h5);
        pll_lock = 1'b0;
        tick(2);
        chk("t5_srst_pre", 32'(sys_rst), 32'd0);
        chk("t5_busy_pre", 32'(cfg_if.cfg_busy), 32'd1);
        tick(1);
        chk("t5_lost", 32'(lock_lost_cnt), 32'd1);
        chk("t5_srst", 32'(sys_rst), 32'd1);
        chk("t5_prst", 32'(pll_reset), 32'd1);
        chk("t5_ack_none", 32'(cfg_if.cfg_ack), 32'd0);
        chk("t5_busy", 32'(cfg_if.cfg_busy), 32'd0);
        chk("t5_rdy", 32'(ready), 32'd0);
        cfg_if.cfg_psda = 4'hA;
        cfg_if.cfg_duty = 4'h1;
        tick(1);
        chk("t5_ack_none2", 32'(cfg_if.cfg_ack), 32'd0);
        chk("t5_psda_keep", 32'(pll_psda), 32'h5);
        pll_lock = 1'b1;
        wait_ready("t5_relock", 30);
        chk("t5_psda_relock", 32'(pll_psda), 32'h5);
        chk("t5_duty_relock", 32'(pll_dutyda), 32'h6);
        tick(1);
        chk("t5_held_busy", 32'(cfg_if.cfg_busy), 32'd1);
        tick(1);
        chk("t5_held_psda", 32'(pll_psda), 32'hA);
        chk("t5_held_duty", 32'(pll_dutyda), 32'h1);
        tick(4);
        chk("t5_held_ack", 32'(cfg_if.cfg_ack), 32'd1);
        chk("t5_lost_keep", 32'(lock_lost_cnt), 32'd1);
        cfg_if.cfg_req = 1'b0;

        // Request arriving on the same cycle lock_s falls: lock loss wins.
        bring_up("t5b_up");
        pll_lock = 1'b0;
        tick(2);
        cfg_if.cfg_req  = 1'b1;
        cfg_if.cfg_psda = 4'h7;
        cfg_if.cfg_duty = 4'h7;
        tick(1);
        chk("t5b_busy", 32'(cfg_if.cfg_busy), 32'd0);
        chk("t5b_rdy", 32'(ready), 32'd0);
        chk("t5b_srst", 32'(sys_rst), 32'd1);
        chk("t5b_lost", 32'(lock_lost_cnt), 32'd1);
        chk("t5b_prst", 32'(pll_reset), 32'd1);
        cfg_if.cfg_req = 1'b0;
        tick(2);
        chk("t5b_psda", 32'(pll_psda), 32'h0);

        // Reset during SETTLE.
        bring_up("t6_up");
        cfg_if.cfg_req  = 1'b1;
        cfg_if.cfg_psda = 4'h5;
        cfg_if.cfg_duty = 4'h6;
        tick(3);
        chk("t6_busy_settle", 32'(cfg_if.cfg_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_values("t6_rst");
        cfg_if.cfg_req = 1'b0;

        // Lock-loss counter saturation.
        bring_up("t7_up");
        for (int i = 0; i < 256; i++) begin
            pll_lock = 1'b0;
            tick(3);
            chk("t7_lost", 32'(lock_lost_cnt), (i < 255) ? 32'(i + 1) : 32'd255);
            pll_lock = 1'b1;
            wait_ready("t7_relock", 30);
        end
        chk("t7_lost_sat", 32'(lock_lost_cnt), 32'd255);
        chk("t7_retry", 32'(retry_cnt), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
